// File: rtl/sha256_round_core_if.sv
// Handshake and result bundle for sha256_round_core.
// master: the block feeding chaining words and message blocks.
// slave: the compression core itself.
interface sha256_round_core_if;
   logic         start;
   logic [255:0] hin;
   logic [511:0] block;
   logic         busy;
   logic         done;
   logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;

   modport master (
      output start, hin, block,
      input  busy, done, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out
   );

   modport slave (
      input  start, hin, block,
      output busy, done, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out
   );
endinterface

// File: rtl/sha256_round_core.sv
// SHA-256 compression engine: 64 rounds over one 512-bit block, raw a..h out.
// The final add into H0..H7 is done by the downstream accumulator stages.
// Build option SHA256_UNROLL2_EN: two cascaded rounds per clock (32 RUN cycles).
module sha256_round_core (
   input  logic                clk,
   input  logic                rst,
   sha256_round_core_if.slave  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

`ifdef SHA256_UNROLL2_EN
   localparam logic [5:0] STEP   = 6'd2;
   localparam logic [5:0] LAST_T = 6'd62;
`else
   localparam logic [5:0] STEP   = 6'd1;
   localparam logic [5:0] LAST_T = 6'd63;
`endif

   state_t            state;
   logic [5:0]        t;
   logic [255:0]      st;       // {a,b,c,d,e,f,g,h}
   logic [15:0][31:0] win;      // win[0] is W[t]
   logic              busy_r;
   logic              done_r;

   logic [255:0]      st_nx;
   logic [15:0][31:0] win_nx;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Next schedule word from the current 16-word window (offsets relative to W[t]).
   function automatic logic [31:0] sched(input logic [31:0] w14, input logic [31:0] w9,
                                         input logic [31:0] w1, input logic [31:0] w0);
      return ssig1(w14) + w9 + ssig0(w1) + w0;
   endfunction

   function automatic logic [31:0] k_rom(input logic [5:0] i);
      case (i)
         6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
         6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
         6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
         6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
         6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
         6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
         6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
         6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
         6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
         6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
         6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
         6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
         6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
         6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
         6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
         6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
         6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
         6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
         6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
         6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
         6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
         6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
         6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
         6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
         6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
         6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
         6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
         6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
         6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
         6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
         6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
         6'd62: k_rom = 32'hbef9a3f7;  6'd63: k_rom = 32'hc67178f2;
      endcase
   endfunction

   // One compression round applied to the packed working variables.
   function automatic logic [255:0] round_f(input logic [255:0] s, input logic [31:0] k,
                                            input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
      t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   // Round datapath and schedule window advance for the current t.
   always_comb begin
      st_nx  = round_f(st, k_rom(t), win[0]);
`ifdef SHA256_UNROLL2_EN
      st_nx  = round_f(st_nx, k_rom(t + 6'd1), win[1]);
      win_nx = {sched(win[15], win[10], win[2], win[1]),
                sched(win[14], win[9], win[1], win[0]),
                win[15:2]};
`else
      win_nx = {sched(win[14], win[9], win[1], win[0]), win[15:1]};
`endif
   end

   // Control FSM with registered busy/done; loads state on accept, rounds while RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         t      <= 6'd0;
         st     <= '0;
         win    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  st     <= bus.hin;
                  for (int i = 0; i < 16; i++) win[i] <= bus.block[511 - 32*i -: 32];
                  t      <= 6'd0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               st  <= st_nx;
               win <= win_nx;
               t   <= t + STEP;
               if (t == LAST_T) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign {bus.a_out, bus.b_out, bus.c_out, bus.d_out,
           bus.e_out, bus.f_out, bus.g_out, bus.h_out} = st;
endmodule

// File: tb/tb_sha256_round_core.sv
// Randomized self-checking bench for sha256_round_core against a
// straightforward SHA-256 compression model (full 64-word schedule array).
module tb_sha256_round_core;
`ifdef SHA256_UNROLL2_EN
   localparam int LAT = 32;
`else
   localparam int LAT = 64;
`endif

   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [255:0] ABC_DIGEST = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                          32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   localparam logic [31:0] KT [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha256_round_core_if bus ();
   sha256_round_core dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference compression: raw a..h after 64 rounds, no feed-forward add.
   function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
      for (int i = 0; i < 8; i++) v[i] = h[255 - 32*i -: 32];
      for (int r = 0; r < 64; r++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[r] + w[r];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
   endfunction

   function automatic logic [255:0] addw(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [255:0] outs();
      return {bus.a_out, bus.b_out, bus.c_out, bus.d_out,
              bus.e_out, bus.f_out, bus.g_out, bus.h_out};
   endfunction

   // One compression with optional start re-pulses at cycles rp0/rp1 after the
   // accepting edge and optional input scrambling right after acceptance.
   task automatic do_run(input logic [255:0] h, input logic [511:0] b, input int rp0,
                         input int rp1, input bit scramble, input string tag,
                         output logic [255:0] res);
      int k;
      int busy_cyc;
      bit seen;
      bus.start = 1'b1;
      bus.hin   = h;
      bus.block = b;
      @(negedge clk);
      busy_cyc = 0;
      seen     = 1'b0;
      for (k = 0; k <= LAT + 10; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_cyc++;
         bus.start = (k == rp0 || k == rp1);
         if (scramble && k == 0) begin
            bus.hin   = rand256();
            bus.block = rand512();
         end
      end
      bus.start = 1'b0;
      chk({tag, "_done_seen"}, 256'(seen), 256'd1);
      chk({tag, "_latency"}, 256'(k), 256'(LAT));
      chk({tag, "_busy_cycles"}, 256'(busy_cyc), 256'(LAT));
      res = outs();
      @(negedge clk);
      chk({tag, "_done_width"}, 256'(bus.done), 256'd0);
      chk({tag, "_hold"}, outs(), res);
   endtask

   logic [255:0] r, r1, r2, h1, h2, hs;
   logic [511:0] b1, b2, bs;
   int k1, k2, dcount;

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.hin   = '0;
      bus.block = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 256'(bus.busy), 256'd0);
      chk("reset_done", 256'(bus.done), 256'd0);
      chk("reset_outs", outs(), 256'd0);
      rst = 1'b0;
      @(negedge clk);

      // Known-answer "abc" block.
      do_run(IV, ABC, -1, -1, 1'b0, "abc", r);
      chk("abc_model", r, ref_compress(IV, ABC));
      chk("abc_digest", addw(r, IV), ABC_DIGEST);

      // Start re-pulsed while running must be ignored.
      do_run(IV, ABC, 10, 40, 1'b0, "repulse", r);
      chk("repulse_digest", addw(r, IV), ABC_DIGEST);

      // Abort by reset partway through, then rerun.
      bus.start = 1'b1;
      bus.hin   = IV;
      bus.block = ABC;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 256'(bus.busy), 256'd0);
      chk("midrst_done", 256'(bus.done), 256'd0);
      chk("midrst_outs", outs(), 256'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      repeat (LAT + 5) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      chk("midrst_no_done", 256'(dcount), 256'd0);
      chk("midrst_idle_busy", 256'(bus.busy), 256'd0);
      do_run(IV, ABC, -1, -1, 1'b0, "after_rst", r);
      chk("after_rst_digest", addw(r, IV), ABC_DIGEST);
      dcount = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      chk("after_rst_extra_done", 256'(dcount), 256'd0);

      // Back-to-back blocks with start held high.
      h1 = rand256(); b1 = rand512();
      h2 = rand256(); b2 = rand512();
      bus.start = 1'b1;
      bus.hin   = h1;
      bus.block = b1;
      @(negedge clk);
      bus.hin   = h2;
      bus.block = b2;
      k1 = -1;
      k2 = -1;
      for (int k = 1; k <= 3 * LAT; k++) begin
         @(negedge clk);
         if (bus.done) begin
            if (k1 < 0) begin
               k1 = k;
               r1 = outs();
            end else begin
               k2 = k;
               r2 = outs();
               break;
            end
         end
      end
      bus.start = 1'b0;
      chk("b2b_first_latency", 256'(k1), 256'(LAT));
      chk("b2b_spacing", 256'(k2 - k1), 256'(LAT + 1));
      chk("b2b_first_result", r1, ref_compress(h1, b1));
      chk("b2b_second_result", r2, ref_compress(h2, b2));
      repeat (2) @(negedge clk);

      // All-zero chaining value and block.
      do_run(256'd0, 512'd0, -1, -1, 1'b0, "zero", r);
      chk("zero_a_out", 256'(r[255:224]), 256'(ref_compress(256'd0, 512'd0) >> 224));
      chk("zero_all", r, ref_compress(256'd0, 512'd0));

      // Inputs change right after acceptance; result must reflect the sampled ones.
      hs = rand256();
      bs = rand512();
      do_run(hs, bs, -1, -1, 1'b1, "scramble", r);
      chk("scramble_result", r, ref_compress(hs, bs));

      // Plain random blocks.
      for (int i = 0; i < 3; i++) begin
         hs = rand256();
         bs = rand512();
         do_run(hs, bs, -1, -1, 1'b0, "random", r);
         chk("random_result", r, ref_compress(hs, bs));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
